packer_stuffer_dct_manager: RTL and testbench

PACKER_STUFFER_DCT_MANAGER -- requirements
Module: packer_stuffer_dct_manager

---
 rtl/packer_stuffer_dct_manager_if.sv | 38 +++
 rtl/packer_stuffer_dct_manager.sv | 164 ++++++++++++++++
 tb/tb_packer_stuffer_dct_manager.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/packer_stuffer_dct_manager_if.sv
// Bundles the DCT-manager, bitpacker and bytestuffer signals of packer_stuffer_dct_manager.
// The master modport drives the block inputs; the slave modport is the block itself.
interface packer_stuffer_dct_manager_if;
    logic        ingester_frontbuffer_select;
    logic        dcts_finished;
    logic [2:0]  mcu_groups_processed;
    logic [1:0]  dcts_frontbuffer;
    logic        dct_nreset;
    logic        bp_data_in_valid;
    logic [31:0] bp_data_in;
    logic [5:0]  bp_input_length;
    logic        bp_flush;
    logic        bp_data_out_valid;
    logic [31:0] bp_data_out;
    logic        bs_data_in_valid;
    logic [7:0]  bs_data_in;
    logic        bs_data_in_ready;
    logic        bs_data_out_valid;
    logic [7:0]  bs_data_out;

    modport master (
        output ingester_frontbuffer_select, dcts_finished,
        output bp_data_in_valid, bp_data_in, bp_input_length, bp_flush,
        output bs_data_in_valid, bs_data_in,
        input  mcu_groups_processed, dcts_frontbuffer, dct_nreset,
        input  bp_data_out_valid, bp_data_out,
        input  bs_data_in_ready, bs_data_out_valid, bs_data_out
    );

    modport slave (
        input  ingester_frontbuffer_select, dcts_finished,
        input  bp_data_in_valid, bp_data_in, bp_input_length, bp_flush,
        input  bs_data_in_valid, bs_data_in,
        output mcu_groups_processed, dcts_frontbuffer, dct_nreset,
        output bp_data_out_valid, bp_data_out,
        output bs_data_in_ready, bs_data_out_valid, bs_data_out
    );
endinterface

// File: rtl/packer_stuffer_dct_manager.sv
// DCT engine sequencer, MSB-first bitpacker (32-bit words, 1-padded flush) and JPEG 0xFF byte stuffer.
module packer_stuffer_dct_manager #(
    parameter int MCU_GROUPS = 8
) (
    input logic                          clock,
    input logic                          nreset,
    packer_stuffer_dct_manager_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, NEXT} DctState;

    localparam logic [2:0] LAST_GROUP = 3'(MCU_GROUPS - 1);

    DctState     r_state, w_nextState;
    logic        r_selLast, r_pending, r_armed, r_dctNreset;
    logic [2:0]  r_mcu, w_nextMcu;
    logic [1:0]  r_front, w_nextFront;
    logic        w_nextPending, w_nextArmed, w_startReq;

    assign w_startReq = bus.ingester_frontbuffer_select != r_selLast;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state     <= IDLE;
            r_selLast   <= 1'b0;
            r_pending   <= 1'b0;
            r_armed     <= 1'b0;
            r_mcu       <= 3'd0;
            r_front     <= 2'd0;
            r_dctNreset <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_selLast   <= bus.ingester_frontbuffer_select;
            r_pending   <= w_nextPending;
            r_armed     <= w_nextArmed;
            r_mcu       <= w_nextMcu;
            r_front     <= w_nextFront;
            r_dctNreset <= (w_nextState == RUN);
        end
    end

    // r_armed masks dcts_finished in the first RUN cycle, while engines leave reset.
    always_comb begin
        w_nextState   = r_state;
        w_nextMcu     = r_mcu;
        w_nextFront   = r_front;
        w_nextPending = r_pending;
        w_nextArmed   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_startReq || r_pending) begin
                    w_nextState   = RUN;
                    w_nextMcu     = 3'd0;
                    w_nextPending = 1'b0;
                end
            end
            RUN: begin
                w_nextArmed = 1'b1;
                if (w_startReq) w_nextPending = 1'b1;
                if (r_armed && bus.dcts_finished) begin
                    w_nextFront = r_front + 2'd1;
                    if (r_mcu == LAST_GROUP) begin
                        w_nextMcu   = 3'd0;
                        w_nextState = IDLE;
                    end else begin
                        w_nextMcu   = r_mcu + 3'd1;
                        w_nextState = NEXT;
                    end
                end
            end
            NEXT: begin
                if (w_startReq) w_nextPending = 1'b1;
                w_nextState = RUN;
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign bus.mcu_groups_processed = r_mcu;
    assign bus.dcts_frontbuffer     = r_front;
    assign bus.dct_nreset           = r_dctNreset;

    logic [63:0] r_stream;
    logic [6:0]  r_count;
    logic        r_flushPend, r_bpValid;
    logic [31:0] r_bpOut;
    logic [6:0]  w_len, w_count;
    logic [31:0] w_mask, w_masked;
    logic [63:0] w_append, w_stream;
    logic        w_doFlush;

    // Stream is left-aligned in r_stream: the oldest pending bit sits at bit 63.
    assign w_len     = !bus.bp_data_in_valid ? 7'd0 :
                       (bus.bp_input_length > 6'd32) ? 7'd32 : {1'b0, bus.bp_input_length};
    assign w_mask    = (w_len >= 7'd32) ? 32'hFFFF_FFFF : ((32'h1 << w_len) - 32'h1);
    assign w_masked  = bus.bp_data_in & w_mask;
    assign w_append  = ({32'b0, w_masked} << (7'd64 - w_len)) >> r_count;
    assign w_stream  = r_stream | w_append;
    assign w_count   = r_count + w_len;
    assign w_doFlush = bus.bp_flush || r_flushPend;

    // A flush that overflows a full word emits that word first and pads the remainder next cycle.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_stream    <= 64'd0;
            r_count     <= 7'd0;
            r_flushPend <= 1'b0;
            r_bpValid   <= 1'b0;
            r_bpOut     <= 32'd0;
        end else begin
            r_bpValid   <= 1'b0;
            r_flushPend <= 1'b0;
            if (w_count >= 7'd32) begin
                r_bpValid   <= 1'b1;
                r_bpOut     <= w_stream[63:32];
                r_stream    <= w_stream << 32;
                r_count     <= w_count - 7'd32;
                r_flushPend <= w_doFlush && (w_count > 7'd32);
            end else if (w_doFlush && (w_count != 7'd0)) begin
                r_bpValid <= 1'b1;
                r_bpOut   <= w_stream[63:32] | (32'hFFFF_FFFF >> w_count);
                r_stream  <= 64'd0;
                r_count   <= 7'd0;
            end else begin
                r_stream <= w_stream;
                r_count  <= w_count;
            end
        end
    end

    assign bus.bp_data_out_valid = r_bpValid;
    assign bus.bp_data_out       = r_bpOut;

    logic       r_bsValid, r_bsReady, r_stuff;
    logic [7:0] r_bsOut;
    logic       w_accept;

    assign w_accept = bus.bs_data_in_valid && r_bsReady;

    // While an 0xFF is on the output, input is blocked so the following slot carries the 0x00.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_bsValid <= 1'b0;
            r_bsOut   <= 8'd0;
            r_bsReady <= 1'b1;
            r_stuff   <= 1'b0;
        end else if (r_stuff) begin
            r_bsValid <= 1'b1;
            r_bsOut   <= 8'h00;
            r_bsReady <= 1'b1;
            r_stuff   <= 1'b0;
        end else if (w_accept) begin
            r_bsValid <= 1'b1;
            r_bsOut   <= bus.bs_data_in;
            r_bsReady <= bus.bs_data_in != 8'hFF;
            r_stuff   <= bus.bs_data_in == 8'hFF;
        end else begin
            r_bsValid <= 1'b0;
        end
    end

    assign bus.bs_data_in_ready  = r_bsReady;
    assign bus.bs_data_out_valid = r_bsValid;
    assign bus.bs_data_out       = r_bsOut;
endmodule

// File: tb/tb_packer_stuffer_dct_manager.sv
// Directed bench for packer_stuffer_dct_manager: DCT sequencing, bitpacker words/flush, byte stuffing, reset.
module tb_packer_stuffer_dct_manager;
    logic clock = 1'b0;
    logic nreset;
    int   total = 0;
    int   bad = 0;
    int   expFront = 0;
    int   expMcu = 0;
    bit   monEn = 1'b0;
    int   readyLow = 0;
    logic [7:0] outQ[$];
    logic [7:0] expQ[$];

    packer_stuffer_dct_manager_if bus();

    packer_stuffer_dct_manager #(.MCU_GROUPS(8)) dut (
        .clock (clock),
        .nreset(nreset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Collects stuffer output bytes and counts cycles with ready low.
    always @(negedge clock) begin
        if (monEn) begin
            if (bus.bs_data_out_valid === 1'b1) outQ.push_back(bus.bs_data_out);
            if (bus.bs_data_in_ready !== 1'b1) readyLow++;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired got=running exp=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic pulse_finished();
        repeat (9) @(negedge clock);
        bus.dcts_finished = 1'b1;
        @(negedge clock);
        bus.dcts_finished = 1'b0;
    endtask

    task automatic drive_code(input logic [31:0] data, input logic [5:0] len);
        bus.bp_data_in_valid = 1'b1;
        bus.bp_data_in       = data;
        bus.bp_input_length  = len;
        @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.bs_data_in_valid = 1'b1;
        bus.bs_data_in       = b;
        while (bus.bs_data_in_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("[TB] FAIL bs_ready_timeout got=%0d cycles exp=<20", n);
        end
        @(negedge clock);
        bus.bs_data_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        total++; if (bus.dct_nreset !== 1'b0) begin bad++; $display("[TB] FAIL rst_dct_nreset got=%0h exp=0", bus.dct_nreset); end
        total++; if (bus.mcu_groups_processed !== 3'd0) begin bad++; $display("[TB] FAIL rst_mcu got=%0h exp=0", bus.mcu_groups_processed); end
        total++; if (bus.dcts_frontbuffer !== 2'd0) begin bad++; $display("[TB] FAIL rst_front got=%0h exp=0", bus.dcts_frontbuffer); end
        total++; if (bus.bp_data_out_valid !== 1'b0 || bus.bp_data_out !== 32'd0) begin bad++; $display("[TB] FAIL rst_bp got=%0h/%h exp=0/0", bus.bp_data_out_valid, bus.bp_data_out); end
        total++; if (bus.bs_data_out_valid !== 1'b0 || bus.bs_data_out !== 8'd0 || bus.bs_data_in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_bs got=%0h/%h/%0h exp=0/00/1", bus.bs_data_out_valid, bus.bs_data_out, bus.bs_data_in_ready); end
        nreset = 1'b1;
        repeat (2) @(negedge clock);
        total++; if (bus.dct_nreset !== 1'b0) begin bad++; $display("[TB] FAIL idle_no_start got=%0h exp=0", bus.dct_nreset); end
    endtask

    task automatic test_dct_run();
        bus.ingester_frontbuffer_select = 1'b1;
        @(negedge clock);
        total++; if (bus.dct_nreset !== 1'b1 || bus.mcu_groups_processed !== 3'd0) begin bad++; $display("[TB] FAIL run_start got=%0h/%0d exp=1/0", bus.dct_nreset, bus.mcu_groups_processed); end
        for (int g = 0; g < 8; g++) begin
            pulse_finished();
            expFront = (expFront + 1) % 4;
            expMcu   = (g == 7) ? 0 : g + 1;
            total++; if (bus.dcts_frontbuffer !== 2'(expFront)) begin bad++; $display("[TB] FAIL run_front g=%0d got=%0d exp=%0d", g, bus.dcts_frontbuffer, expFront); end
            total++; if (bus.mcu_groups_processed !== 3'(expMcu)) begin bad++; $display("[TB] FAIL run_mcu g=%0d got=%0d exp=%0d", g, bus.mcu_groups_processed, expMcu); end
            total++; if (bus.dct_nreset !== 1'b0) begin bad++; $display("[TB] FAIL run_pulse_low g=%0d got=%0h exp=0", g, bus.dct_nreset); end
            @(negedge clock);
            total++; if (bus.dct_nreset !== ((g == 7) ? 1'b0 : 1'b1)) begin bad++; $display("[TB] FAIL run_pulse_end g=%0d got=%0h exp=%0h", g, bus.dct_nreset, (g == 7) ? 1'b0 : 1'b1); end
        end
        repeat (5) @(negedge clock);
        total++; if (bus.dct_nreset !== 1'b0 || bus.dcts_frontbuffer !== 2'd0) begin bad++; $display("[TB] FAIL run_end_idle got=%0h/%0d exp=0/0", bus.dct_nreset, bus.dcts_frontbuffer); end
    endtask

    task automatic test_dct_pending();
        bus.ingester_frontbuffer_select = 1'b0;
        @(negedge clock);
        total++; if (bus.dct_nreset !== 1'b1) begin bad++; $display("[TB] FAIL pend_start got=%0h exp=1", bus.dct_nreset); end
        repeat (2) @(negedge clock);
        bus.ingester_frontbuffer_select = 1'b1;
        repeat (2) @(negedge clock);
        bus.ingester_frontbuffer_select = 1'b0;
        for (int g = 0; g < 8; g++) pulse_finished();
        total++; if (bus.dct_nreset !== 1'b0 || bus.mcu_groups_processed !== 3'd0) begin bad++; $display("[TB] FAIL pend_first_end got=%0h/%0d exp=0/0", bus.dct_nreset, bus.mcu_groups_processed); end
        @(negedge clock);
        total++; if (bus.dct_nreset !== 1'b1 || bus.mcu_groups_processed !== 3'd0) begin bad++; $display("[TB] FAIL pend_restart got=%0h/%0d exp=1/0", bus.dct_nreset, bus.mcu_groups_processed); end
        for (int g = 0; g < 8; g++) begin
            pulse_finished();
            expMcu = (g == 7) ? 0 : g + 1;
            total++; if (bus.mcu_groups_processed !== 3'(expMcu)) begin bad++; $display("[TB] FAIL pend_mcu g=%0d got=%0d exp=%0d", g, bus.mcu_groups_processed, expMcu); end
        end
        repeat (6) @(negedge clock);
        total++; if (bus.dct_nreset !== 1'b0) begin bad++; $display("[TB] FAIL pend_single_extra got=%0h exp=0", bus.dct_nreset); end
        total++; if (bus.dcts_frontbuffer !== 2'd0) begin bad++; $display("[TB] FAIL pend_front got=%0d exp=0", bus.dcts_frontbuffer); end
    endtask

    task automatic test_bitpacker();
        drive_code(32'h5, 6'd3);
        drive_code(32'h1FFF_FFFF, 6'd29);
        bus.bp_data_in_valid = 1'b0;
        total++; if (bus.bp_data_out_valid !== 1'b1 || bus.bp_data_out !== 32'hBFFF_FFFF) begin bad++; $display("[TB] FAIL bp_word got=%0h/%h exp=1/bfffffff", bus.bp_data_out_valid, bus.bp_data_out); end
        @(negedge clock);
        total++; if (bus.bp_data_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_single_strobe got=%0h exp=0", bus.bp_data_out_valid); end
        drive_code(32'hFFFF_FFF0, 6'd4);
        drive_code(32'hDEAD_BEEF, 6'd0);
        drive_code(32'h0FFF_FFFF, 6'd28);
        bus.bp_data_in_valid = 1'b0;
        total++; if (bus.bp_data_out_valid !== 1'b1 || bus.bp_data_out !== 32'h0FFF_FFFF) begin bad++; $display("[TB] FAIL bp_mask_len0 got=%0h/%h exp=1/0fffffff", bus.bp_data_out_valid, bus.bp_data_out); end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        drive_code(32'h1234, 6'd16);
        drive_code(32'h5678, 6'd16);
        total++; if (bus.bp_data_out_valid !== 1'b1 || bus.bp_data_out !== 32'h1234_5678) begin bad++; $display("[TB] FAIL b2b_word got=%0h/%h exp=1/12345678", bus.bp_data_out_valid, bus.bp_data_out); end
        drive_code(32'h9ABC, 6'd16);
        total++; if (bus.bp_data_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_partial got=%0h exp=0", bus.bp_data_out_valid); end
        bus.bp_data_in_valid = 1'b0;
        bus.bp_flush = 1'b1;
        @(negedge clock);
        bus.bp_flush = 1'b0;
        total++; if (bus.bp_data_out_valid !== 1'b1 || bus.bp_data_out !== 32'h9ABC_FFFF) begin bad++; $display("[TB] FAIL b2b_flush got=%0h/%h exp=1/9abcffff", bus.bp_data_out_valid, bus.bp_data_out); end
        drive_code(32'h7, 6'd3);
        bus.bp_flush = 1'b1;
        drive_code(32'hCAFE_BABE, 6'd32);
        bus.bp_data_in_valid = 1'b0;
        bus.bp_flush = 1'b0;
        total++; if (bus.bp_data_out_valid !== 1'b1 || bus.bp_data_out !== 32'hF95F_D757) begin bad++; $display("[TB] FAIL b2b_len32 got=%0h/%h exp=1/f95fd757", bus.bp_data_out_valid, bus.bp_data_out); end
        @(negedge clock);
        total++; if (bus.bp_data_out_valid !== 1'b1 || bus.bp_data_out !== 32'hDFFF_FFFF) begin bad++; $display("[TB] FAIL b2b_overflow_flush got=%0h/%h exp=1/dfffffff", bus.bp_data_out_valid, bus.bp_data_out); end
        @(negedge clock);
    endtask

    task automatic test_flush();
        drive_code(32'h3, 6'd2);
        bus.bp_data_in_valid = 1'b0;
        bus.bp_flush = 1'b1;
        @(negedge clock);
        bus.bp_flush = 1'b0;
        total++; if (bus.bp_data_out_valid !== 1'b1 || bus.bp_data_out !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL flush_ones got=%0h/%h exp=1/ffffffff", bus.bp_data_out_valid, bus.bp_data_out); end
        drive_code(32'h0, 6'd4);
        bus.bp_data_in_valid = 1'b0;
        bus.bp_flush = 1'b1;
        @(negedge clock);
        bus.bp_flush = 1'b0;
        total++; if (bus.bp_data_out_valid !== 1'b1 || bus.bp_data_out !== 32'h0FFF_FFFF) begin bad++; $display("[TB] FAIL flush_zeros got=%0h/%h exp=1/0fffffff", bus.bp_data_out_valid, bus.bp_data_out); end
        bus.bp_flush = 1'b1;
        drive_code(32'hA, 6'd4);
        bus.bp_data_in_valid = 1'b0;
        bus.bp_flush = 1'b0;
        total++; if (bus.bp_data_out_valid !== 1'b1 || bus.bp_data_out !== 32'hAFFF_FFFF) begin bad++; $display("[TB] FAIL flush_same_cycle got=%0h/%h exp=1/afffffff", bus.bp_data_out_valid, bus.bp_data_out); end
        bus.bp_flush = 1'b1;
        @(negedge clock);
        bus.bp_flush = 1'b0;
        total++; if (bus.bp_data_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_empty got=%0h exp=0", bus.bp_data_out_valid); end
    endtask

    task automatic test_bytestuffer();
        outQ.delete(); readyLow = 0; monEn = 1'b1;
        send_byte(8'h12); send_byte(8'hFF); send_byte(8'h34);
        repeat (4) @(negedge clock);
        monEn = 1'b0;
        expQ = '{8'h12, 8'hFF, 8'h00, 8'h34};
        total++; if (outQ.size() != 4) begin bad++; $display("[TB] FAIL bs_count1 got=%0d exp=4", outQ.size()); end
        for (int i = 0; i < 4 && i < outQ.size(); i++) begin
            total++; if (outQ[i] !== expQ[i]) begin bad++; $display("[TB] FAIL bs_byte1[%0d] got=%h exp=%h", i, outQ[i], expQ[i]); end
        end
        total++; if (readyLow != 1) begin bad++; $display("[TB] FAIL bs_ready_low1 got=%0d exp=1", readyLow); end
        outQ.delete(); readyLow = 0; monEn = 1'b1;
        send_byte(8'hFF); send_byte(8'hFF);
        repeat (4) @(negedge clock);
        monEn = 1'b0;
        expQ = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        total++; if (outQ.size() != 4) begin bad++; $display("[TB] FAIL bs_count2 got=%0d exp=4", outQ.size()); end
        for (int i = 0; i < 4 && i < outQ.size(); i++) begin
            total++; if (outQ[i] !== expQ[i]) begin bad++; $display("[TB] FAIL bs_byte2[%0d] got=%h exp=%h", i, outQ[i], expQ[i]); end
        end
        total++; if (readyLow != 2) begin bad++; $display("[TB] FAIL bs_ready_low2 got=%0d exp=2", readyLow); end
    endtask

    task automatic test_reset_mid();
        bus.ingester_frontbuffer_select = 1'b1;
        send_byte(8'hAB);
        drive_code(32'hF, 6'd4);
        bus.bp_data_in_valid = 1'b0;
        pulse_finished();
        repeat (3) @(negedge clock);
        total++; if (bus.dct_nreset !== 1'b1 || bus.dcts_frontbuffer !== 2'd1) begin bad++; $display("[TB] FAIL mid_pre_run got=%0h/%0d exp=1/1", bus.dct_nreset, bus.dcts_frontbuffer); end
        nreset = 1'b0;
        bus.ingester_frontbuffer_select = 1'b0;
        #1;
        total++; if (bus.dct_nreset !== 1'b0 || bus.mcu_groups_processed !== 3'd0 || bus.dcts_frontbuffer !== 2'd0) begin bad++; $display("[TB] FAIL mid_dct got=%0h/%0d/%0d exp=0/0/0", bus.dct_nreset, bus.mcu_groups_processed, bus.dcts_frontbuffer); end
        total++; if (bus.bp_data_out_valid !== 1'b0 || bus.bp_data_out !== 32'd0) begin bad++; $display("[TB] FAIL mid_bp got=%0h/%h exp=0/0", bus.bp_data_out_valid, bus.bp_data_out); end
        total++; if (bus.bs_data_out_valid !== 1'b0 || bus.bs_data_out !== 8'd0 || bus.bs_data_in_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_bs got=%0h/%h/%0h exp=0/00/1", bus.bs_data_out_valid, bus.bs_data_out, bus.bs_data_in_ready); end
        @(negedge clock);
        nreset = 1'b1;
        drive_code(32'h0, 6'd1);
        bus.bp_data_in_valid = 1'b0;
        bus.bp_flush = 1'b1;
        @(negedge clock);
        bus.bp_flush = 1'b0;
        total++; if (bus.bp_data_out_valid !== 1'b1 || bus.bp_data_out !== 32'h7FFF_FFFF) begin bad++; $display("[TB] FAIL mid_fresh_stream got=%0h/%h exp=1/7fffffff", bus.bp_data_out_valid, bus.bp_data_out); end
        repeat (3) @(negedge clock);
        total++; if (bus.dct_nreset !== 1'b0) begin bad++; $display("[TB] FAIL mid_no_pending got=%0h exp=0", bus.dct_nreset); end
    endtask

    initial begin
        nreset = 1'b0;
        bus.ingester_frontbuffer_select = 1'b0;
        bus.dcts_finished    = 1'b0;
        bus.bp_data_in_valid = 1'b0;
        bus.bp_data_in       = 32'd0;
        bus.bp_input_length  = 6'd0;
        bus.bp_flush         = 1'b0;
        bus.bs_data_in_valid = 1'b0;
        bus.bs_data_in       = 8'd0;
        test_reset();
        test_dct_run();
        test_dct_pending();
        test_bitpacker();
        test_back_to_back();
        test_flush();
        test_bytestuffer();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
